// File: rtl/ff_write_arbiter.sv
// rtl/ff_write_arbiter.sv - round-robin arbiter sharing one W-bit register among N writers
// A tenure ends on a dropped request or after MAX_HOLD writes, re-arbitrating in the same edge.
module ff_write_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       wdata,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] owner,
   output logic [W-1:0]         q,
   output logic                 q_valid,
   output logic                 busy
);

   localparam int PW = $clog2(N);
   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    q_q, q_d;
   logic            q_valid_q, q_valid_d;

   logic            rearb;
   logic [PW-1:0]   arb_ptr;
   logic [PW:0]     arb_res;
   logic [CW-1:0]   cnt_inc;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
      if (v == PW'(N - 1)) return '0;
      return v + PW'(1);
   endfunction

   // Returns {found, index} of the first requester at or after p, cyclically.
   function automatic logic [PW:0] pick(input logic [N-1:0] r, input logic [PW-1:0] p);
      logic [PW-1:0] idx;
      logic [PW:0]   res;
      idx = p;
      res = '0;
      for (int k = 0; k < N; k++) begin
         if (!res[PW] && r[idx]) res = {1'b1, idx};
         idx = wrap_inc(idx);
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      q_valid_d = q_valid_q;
      rearb     = 1'b0;
      arb_ptr   = ptr_q;
      cnt_inc   = cnt_q + CW'(1);

      case (state_q)
         IDLE: rearb = 1'b1;
         GRANTED: begin
            if (req[owner_q]) begin
               q_d       = wdata[int'(owner_q)*W +: W];
               q_valid_d = 1'b1;
               cnt_d     = cnt_inc;
               if (cnt_inc == CW'(MAX_HOLD)) begin
                  rearb   = 1'b1;
                  ptr_d   = wrap_inc(owner_q);
                  arb_ptr = ptr_d;
               end
            end else begin
               rearb   = 1'b1;
               ptr_d   = wrap_inc(owner_q);
               arb_ptr = ptr_d;
            end
         end
         default: rearb = 1'b1;
      endcase

      arb_res = pick(req, arb_ptr);
      if (rearb) begin
         cnt_d = '0;
         if (arb_res[PW]) begin
            state_d = GRANTED;
            owner_d = arb_res[PW-1:0];
         end else begin
            state_d = IDLE;
            owner_d = '0;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (state_q == GRANTED) gnt[owner_q] = 1'b1;
      busy    = |gnt;
      owner   = owner_q;
      q       = q_q;
      q_valid = q_valid_q;
   end

endmodule

// File: tb/tb_ff_write_arbiter.sv
// tb/tb_ff_write_arbiter.sv - scoreboard bench for ff_write_arbiter (N=4, W=8, MAX_HOLD=4)
module tb_ff_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic [7:0]  q;
   logic        q_valid;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   ff_write_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset), .req(req), .wdata(wdata),
      .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ex(input logic [3:0] g, input logic [1:0] o,
                                      input logic qv, input logic [7:0] qq);
      return {g, o, |g, qv, qq};
   endfunction

   function automatic logic [15:0] obs();
      return {gnt, owner, busy, q_valid, q};
   endfunction

   task automatic drive(input logic rn, input logic [3:0] r, input logic [31:0] wd,
                        input logic [15:0] e);
      reset = rn;
      req   = r;
      wdata = wd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 4'($urandom), $urandom, ex(4'b0, 2'd0, 1'b0, 8'h00));
         e = exp_q.pop_front(); checks++;
         if (obs() !== e) begin failures++; $display("FAIL reset e%0d got=%h exp=%h", i, obs(), e); end
      end
   endtask

   task automatic test_single();
      logic [15:0] e;
      for (int i = 0; i < 4; i++) begin
         if (i == 0)      drive(1'b1, 4'b0100, 32'h00A5_0000, ex(4'b0100, 2'd2, 1'b0, 8'h00));
         else if (i < 3)  drive(1'b1, 4'b0100, 32'h00A5_0000, ex(4'b0100, 2'd2, 1'b1, 8'hA5));
         else             drive(1'b1, 4'b0000, 32'h00A5_0000, ex(4'b0000, 2'd0, 1'b1, 8'hA5));
         e = exp_q.pop_front(); checks++;
         if (obs() !== e) begin failures++; $display("FAIL single e%0d got=%h exp=%h", i, obs(), e); end
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] e;
      logic [1:0]  o;
      logic [7:0]  v;
      drive(1'b0, 4'b0000, 32'h0, ex(4'b0, 2'd0, 1'b0, 8'h00));
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL rr_reset got=%h exp=%h", obs(), e); end
      for (int k = 1; k <= 22; k++) begin
         o = 2'(((k - 1) / 4) % 4);
         v = 8'h10 + 8'(((k - 2) / 4) % 4);
         if (k == 1)       drive(1'b1, 4'b1111, 32'h1312_1110, ex(4'b0001, 2'd0, 1'b0, 8'h00));
         else if (k < 22)  drive(1'b1, 4'b1111, 32'h1312_1110, ex(4'b0001 << o, o, 1'b1, v));
         else              drive(1'b1, 4'b0000, 32'h1312_1110, ex(4'b0000, 2'd0, 1'b1, 8'h10));
         e = exp_q.pop_front(); checks++;
         if (obs() !== e) begin failures++; $display("FAIL round_robin e%0d got=%h exp=%h", k, obs(), e); end
      end
   endtask

   task automatic test_lone_forced();
      logic [15:0] e;
      logic [7:0]  v;
      drive(1'b0, 4'b0000, 32'h0, ex(4'b0, 2'd0, 1'b0, 8'h00));
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL lone_reset got=%h exp=%h", obs(), e); end
      for (int k = 1; k <= 11; k++) begin
         v = 8'h40 + 8'(k);
         if (k == 1)       drive(1'b1, 4'b0001, {24'hEEEEEE, v}, ex(4'b0001, 2'd0, 1'b0, 8'h00));
         else if (k < 11)  drive(1'b1, 4'b0001, {24'hEEEEEE, v}, ex(4'b0001, 2'd0, 1'b1, v));
         else              drive(1'b1, 4'b0000, {24'hEEEEEE, v}, ex(4'b0000, 2'd0, 1'b1, 8'h4A));
         e = exp_q.pop_front(); checks++;
         if (obs() !== e) begin failures++; $display("FAIL lone_forced e%0d got=%h exp=%h", k, obs(), e); end
      end
   endtask

   task automatic test_voluntary();
      logic [15:0] e;
      logic [31:0] wd;
      drive(1'b0, 4'b0000, 32'h0, ex(4'b0, 2'd0, 1'b0, 8'h00));
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL vol_reset got=%h exp=%h", obs(), e); end
      for (int k = 1; k <= 6; k++) begin
         wd = 32'hxxxx_xxxx;
         case (k)
            1: begin wd[15:8] = 8'h20; drive(1'b1, 4'b0010, wd, ex(4'b0010, 2'd1, 1'b0, 8'h00)); end
            2: begin wd[15:8] = 8'h21; drive(1'b1, 4'b1010, wd, ex(4'b0010, 2'd1, 1'b1, 8'h21)); end
            3: begin wd[15:8] = 8'h22; drive(1'b1, 4'b1010, wd, ex(4'b0010, 2'd1, 1'b1, 8'h22)); end
            4: begin wd[31:24] = 8'h33; drive(1'b1, 4'b1000, wd, ex(4'b1000, 2'd3, 1'b1, 8'h22)); end
            5: begin wd[31:24] = 8'h33; drive(1'b1, 4'b1000, wd, ex(4'b1000, 2'd3, 1'b1, 8'h33)); end
            default: begin wd = 32'h0; drive(1'b1, 4'b0000, wd, ex(4'b0000, 2'd0, 1'b1, 8'h33)); end
         endcase
         e = exp_q.pop_front(); checks++;
         if (obs() !== e) begin failures++; $display("FAIL voluntary e%0d got=%h exp=%h", k, obs(), e); end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] e;
      drive(1'b0, 4'b0000, 32'h0, ex(4'b0, 2'd0, 1'b0, 8'h00));
      e = exp_q.pop_front(); checks++;
      if (obs() !== e) begin failures++; $display("FAIL mid_pre_reset got=%h exp=%h", obs(), e); end
      for (int k = 1; k <= 7; k++) begin
         case (k)
            1: drive(1'b1, 4'b0100, 32'h0050_0000, ex(4'b0100, 2'd2, 1'b0, 8'h00));
            2: drive(1'b1, 4'b0100, 32'h0051_0000, ex(4'b0100, 2'd2, 1'b1, 8'h51));
            3: drive(1'b1, 4'b0100, 32'h0052_0000, ex(4'b0100, 2'd2, 1'b1, 8'h52));
            4: drive(1'b0, 4'b0100, 32'h0053_0000, ex(4'b0000, 2'd0, 1'b0, 8'h00));
            5: drive(1'b1, 4'b0110, 32'h0070_6100, ex(4'b0010, 2'd1, 1'b0, 8'h00));
            6: drive(1'b1, 4'b0110, 32'h0070_6100, ex(4'b0010, 2'd1, 1'b1, 8'h61));
            default: drive(1'b1, 4'b0000, 32'h0, ex(4'b0000, 2'd0, 1'b1, 8'h61));
         endcase
         e = exp_q.pop_front(); checks++;
         if (obs() !== e) begin failures++; $display("FAIL reset_mid e%0d got=%h exp=%h", k, obs(), e); end
      end
   endtask

   initial begin
      reset = 1'b0;
      req   = '0;
      wdata = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_lone_forced();
      test_voluntary();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ff_write_arbiter.md
Name: ff_write_arbiter

Overview:
- Round-robin arbiter that shares one W-bit D-flip-flop register among N requesters.
- Each requester raises req and drives its data word. The arbiter grants exactly one owner at a time and loads the owner's data into the shared register every granted cycle.
- Tenure is bounded by MAX_HOLD so no requester can starve the others.
- Sits between the lab's register/flip-flop datapath and multiple writer blocks.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, shared register width in bits
- MAX_HOLD, 4, maximum consecutive writes per tenure (>=1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset; reset=0 at a rising edge clears all state
- req  input  N  request per requester; must stay high for the whole intended tenure
- wdata  input  N*W  packed write data; requester i uses bits [i*W +: W]
- gnt  output  N  one-hot grant; all zero when idle
- owner  output  $clog2(N)  index of the current owner; 0 when idle
- q  output  W  shared register contents
- q_valid  output  1  high once q has been written since reset
- busy  output  1  high whenever any gnt bit is high

Behaviour:
- Reset (reset=0 at an edge):
  - gnt=0, owner=0, busy=0, q=0, q_valid=0.
  - Tenure counter=0, round-robin pointer=0 (requester 0 has highest priority first).
  - Reset overrides every other event, including an in-progress tenure.
- States:
  - IDLE (gnt=0) and GRANTED (one gnt bit high). Two states only; counter and pointer are separate registers.
- IDLE -> GRANTED:
  - At an edge with any req high, the winner is the first requester with req=1, searching cyclically from pointer.
  - From that edge: gnt[winner]=1, owner=winner, tenure counter=0.
  - Latency: req rise to gnt is 1 edge.
- GRANTED, write:
  - At each edge with gnt[owner]=1 and req[owner]=1: q <= wdata[owner], q_valid <= 1, counter increments.
  - The first write occurs at the edge after the grant edge.
- GRANTED, release:
  - Trigger A, voluntary: req[owner]=0 at an edge. No write occurs that edge.
  - Trigger B, forced: the counter reaches MAX_HOLD, i.e. this edge performs the MAX_HOLD-th write.
  - On release, pointer <= owner+1 mod N.
  - Re-arbitration happens in the same edge from the new pointer, with no idle gap: if any req is high, the new winner is granted immediately with counter=0.
  - Otherwise the arbiter goes to IDLE.
  - After a forced release the previous owner may win again only if no other requester is requesting; this starts a fresh tenure.
- Simultaneous requests: only the round-robin order decides the winner; index order does not.
- Requests arriving mid-tenure wait; they do not preempt the owner.
- Output invariants:
  - gnt is always one-hot or zero.
  - q changes only at edges where a write occurs.
  - busy equals the OR of gnt.
- Width rules:
  - Counter width is $clog2(MAX_HOLD+1).
  - Pointer and owner width is $clog2(N); the pointer wraps N-1 -> 0.
- X/undriven wdata from non-owners has no effect.

Test Plan:
- Reset: hold reset=0 for 2 edges with random req/wdata -> gnt=0, owner=0, busy=0, q=0x00, q_valid=0 after each edge.
- Single requester:
  - Stimulus: req=0b0100 held 3 edges, wdata[2]=0xA5, then req=0.
  - Response: gnt=0b0100 after edge 1, q=0xA5 and q_valid=1 after edge 2; gnt=0 after the edge where req drops.
- Round-robin fairness:
  - Stimulus: req=0b1111 held; each requester drives data 0x10+i.
  - Response: owners 0,1,2,3,0 in order; each tenure gives exactly 4 writes (MAX_HOLD=4); q sequence 0x10 x4, 0x11 x4, ...; no idle cycle between tenures.
- Forced release with a lone requester:
  - Stimulus: req=0b0001 held for 10 edges.
  - Response: gnt stays 0b0001 continuously across tenures; q written every edge except the grant edge.
- Voluntary release plus a waiting requester:
  - Stimulus: owner 1 drops req after 2 writes while req[3]=1.
  - Response: gnt=0b1000 at that same edge, and q keeps owner 1's last value until the next edge.
- Reset mid-tenure:
  - Stimulus: reset=0 during owner 2's 3rd write edge.
  - Response: gnt=0, q=0x00, q_valid=0; after release with req=0b0110, owner=1 (pointer restarted at 0).
